// File: rtl/ring_osc_pkg.sv
// Shared defaults and FSM encoding for the ring oscillator measurement scheduler.
package ring_osc_pkg;
  localparam int NUM_RING_DEF   = 7;
  localparam int SETTLE_CYC_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_COUNT  = 2'd2,
    ST_REPORT = 2'd3
  } state_e;
endpackage

// File: rtl/ring_osc_sched_sync.sv
// Two-flop synchronizer plus rising-edge detector for the selected ring.
module ring_sync (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  input  logic ring,
  output logic rise
);
  // sh[0..1] synchronize, sh[2] is the previous synchronized sample
  logic [2:0] sh;

  always_ff @(posedge clk) begin
    if (rst || flush) sh <= '0;
    else              sh <= {sh[1:0], ring};
  end

  assign rise = sh[1] & ~sh[2];
endmodule

// File: rtl/ring_osc_sched.sv
// Sweeps the masked ring oscillators one at a time: enable, settle, count edges
// over a gate window, then hand the result out on a valid/ready port.
module ring_osc_sched
  import ring_osc_pkg::*;
#(
  parameter int NUM_RING   = NUM_RING_DEF,
  parameter int CNT_W      = 16,
  parameter int WIN_W      = 16,
  parameter int SETTLE_CYC = SETTLE_CYC_DEF
) (
`ifdef USE_POWER_PINS
  inout  wire                 vccd1,
  inout  wire                 vssd1,
`endif
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  input  logic [NUM_RING-1:0] ring_i,
  output logic [NUM_RING-1:0] ring_en_o,
  input  logic                start_i,
  input  logic                abort_i,
  input  logic                continuous_i,
  input  logic [NUM_RING-1:0] ring_mask_i,
  input  logic [WIN_W-1:0]    win_len_i,
  output logic                res_valid_o,
  input  logic                res_ready_i,
  output logic [2:0]          res_idx_o,
  output logic [CNT_W-1:0]    res_count_o,
  output logic                busy_o,
  output logic                done_o
);
  localparam int SW = $clog2(SETTLE_CYC);
  localparam logic [NUM_RING-1:0] ONE = NUM_RING'(1);

  state_e              state, nstate;
  logic [NUM_RING-1:0] mask_q;
  logic [WIN_W-1:0]    win_q, win_cnt;
  logic [SW-1:0]       settle_cnt;
  logic [2:0]          sel_idx, res_idx;
  logic [CNT_W-1:0]    cnt, cnt_nxt, res_cnt;
  logic                done_q;
  logic                meas, ring_sel, rise;
  logic [2:0]          in_lo, mq_lo, mq_hi;
  logic                in_any, hi_any;
  logic                hs, win_last, settle_last;

  // Descending scans: the last hit written is the lowest qualifying bit
  always_comb begin
    in_lo  = '0;
    mq_lo  = '0;
    mq_hi  = '0;
    hi_any = 1'b0;
    for (int i = NUM_RING - 1; i >= 0; i--) begin
      if (ring_mask_i[i]) in_lo = 3'(i);
      if (mask_q[i])      mq_lo = 3'(i);
      if (mask_q[i] && (3'(i) > sel_idx)) begin
        mq_hi  = 3'(i);
        hi_any = 1'b1;
      end
    end
  end

  assign in_any      = |ring_mask_i;
  assign meas        = (state == ST_SETTLE) || (state == ST_COUNT);
  assign ring_sel    = meas ? ring_i[sel_idx] : 1'b0;
  assign hs          = (state == ST_REPORT) && res_ready_i;
  assign settle_last = (settle_cnt == SW'(SETTLE_CYC - 1));
  // A zero window length still gates for one cycle
  assign win_last    = (win_q == '0) || (win_cnt == win_q - WIN_W'(1));
  assign cnt_nxt     = (&cnt) ? cnt : cnt + CNT_W'(rise);

  // Synchronizer is held clear outside SETTLE/COUNT so each ring starts clean
  ring_sync u_sync (
    .clk   (wb_clk_i),
    .rst   (wb_rst_i),
    .flush (!meas),
    .ring  (ring_sel),
    .rise  (rise)
  );

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) state <= ST_IDLE;
    else          state <= nstate;
  end

  always_comb begin
    nstate = state;
    case (state)
      ST_IDLE:   if (start_i && in_any) nstate = ST_SETTLE;
      ST_SETTLE: if (settle_last) nstate = ST_COUNT;
      ST_COUNT:  if (win_last) nstate = ST_REPORT;
      ST_REPORT: if (hs) nstate = (hi_any || continuous_i) ? ST_SETTLE : ST_IDLE;
      default:   nstate = ST_IDLE;
    endcase
    if (abort_i) nstate = ST_IDLE;
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      mask_q     <= '0;
      win_q      <= '0;
      win_cnt    <= '0;
      settle_cnt <= '0;
      sel_idx    <= '0;
      cnt        <= '0;
      res_idx    <= '0;
      res_cnt    <= '0;
      done_q     <= 1'b0;
    end else begin
      done_q     <= (state == ST_IDLE) && start_i && !in_any && !abort_i;
      settle_cnt <= '0;
      case (state)
        ST_IDLE: if (start_i && in_any) begin
          mask_q  <= ring_mask_i;
          win_q   <= win_len_i;
          sel_idx <= in_lo;
        end
        ST_SETTLE: begin
          settle_cnt <= settle_cnt + SW'(1);
          cnt        <= '0;
          win_cnt    <= '0;
        end
        ST_COUNT: begin
          win_cnt <= win_cnt + WIN_W'(1);
          cnt     <= cnt_nxt;
          if (win_last) begin
            res_cnt <= cnt_nxt;
            res_idx <= sel_idx;
          end
        end
        ST_REPORT: if (hs) sel_idx <= hi_any ? mq_hi : mq_lo;
        default: ;
      endcase
    end
  end

  assign ring_en_o   = meas ? (ONE << sel_idx) : '0;
  assign res_valid_o = (state == ST_REPORT);
  assign res_idx_o   = res_idx;
  assign res_count_o = res_cnt;
  assign busy_o      = (state != ST_IDLE);
  assign done_o      = done_q | (hs && !hi_any && !abort_i && !wb_rst_i);
endmodule

// File: tb/tb_ring_osc_sched.sv
// Directed bench for ring_osc_sched: default instance plus a CNT_W=4 instance for saturation.
module tb_ring_osc_sched;
  logic       clk = 1'b0;
  logic       rst, start, start_s, abort, cont, ready;
  logic [6:0] mask, ring, ring_s;
  logic [15:0] win;
  logic [6:0] ring_en, en_s;
  logic       res_valid, valid_s, busy, busy_s, done_o, done_s;
  logic [2:0] res_idx, idx_s;
  logic [15:0] res_cnt;
  logic [3:0] cnt_s;

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  bit multi_en = 1'b0;
  int per = 10, per_s = 4, ph = 0;

  always #5 clk = ~clk;

  ring_osc_sched u_dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .ring_i(ring), .ring_en_o(ring_en),
    .start_i(start), .abort_i(abort), .continuous_i(cont), .ring_mask_i(mask),
    .win_len_i(win), .res_valid_o(res_valid), .res_ready_i(ready),
    .res_idx_o(res_idx), .res_count_o(res_cnt), .busy_o(busy), .done_o(done_o)
  );

  ring_osc_sched #(.CNT_W(4)) u_sat (
    .wb_clk_i(clk), .wb_rst_i(rst), .ring_i(ring_s), .ring_en_o(en_s),
    .start_i(start_s), .abort_i(abort), .continuous_i(cont), .ring_mask_i(mask),
    .win_len_i(win), .res_valid_o(valid_s), .res_ready_i(ready),
    .res_idx_o(idx_s), .res_count_o(cnt_s), .busy_o(busy_s), .done_o(done_s)
  );

  // Free-running square waves; per==0 means constant high
  always @(negedge clk) begin
    ph++;
    ring   = (per == 0)   ? 7'h7f : (((ph % per) < per / 2) ? 7'h7f : 7'h00);
    ring_s = (per_s == 0) ? 7'h7f : (((ph % per_s) < per_s / 2) ? 7'h7f : 7'h00);
  end

  always begin
    @(negedge clk);
    #2;
    if (done_o === 1'b1) done_cnt++;
    if ($countones(ring_en) > 1 || $countones(en_s) > 1) multi_en = 1'b1;
  end

  task automatic pulse_start(input bit sat, input logic [6:0] m, input logic [15:0] w);
    @(negedge clk);
    mask = m; win = w;
    if (sat) start_s = 1'b1; else start = 1'b1;
  endtask

  task automatic wait_valid(input bit sat, output int cyc, output logic [6:0] en_first);
    cyc = 0; en_first = '0;
    while (cyc < 3000) begin
      @(negedge clk);
      start = 1'b0; start_s = 1'b0; ready = 1'b0;
      cyc++;
      #1;
      if (cyc == 1) en_first = sat ? en_s : ring_en;
      if (sat ? valid_s : res_valid) return;
    end
    cyc = -1;
  endtask

  task automatic handshake(output logic d);
    @(negedge clk);
    ready = 1'b1;
    #1;
    d = done_o | done_s;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    n_checks++;
    if ({ring_en, res_valid, res_idx, res_cnt, busy, done_o} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got en=%b v=%b idx=%0d cnt=%0d busy=%b done=%b, expected all 0",
               ring_en, res_valid, res_idx, res_cnt, busy, done_o);
    end
    n_checks++;
    if ({en_s, valid_s, idx_s, cnt_s, busy_s, done_s} !== '0) begin
      n_fail++;
      $display("FAIL reset_sat_outputs: got nonzero outputs, expected all 0");
    end
    rst = 1'b0;
  endtask

  task automatic test_single;
    int cyc; logic [6:0] en; logic d; int dc0;
    per = 10;
    pulse_start(1'b0, 7'b0000001, 16'd100);
    wait_valid(1'b0, cyc, en);
    n_checks++;
    if (cyc != 105) begin n_fail++; $display("FAIL single_latency: got %0d expected 105", cyc); end
    n_checks++;
    if (en !== 7'b0000001) begin n_fail++; $display("FAIL single_en: got %b expected 0000001", en); end
    n_checks++;
    if (res_idx !== 3'd0 || res_cnt !== 16'd10) begin
      n_fail++; $display("FAIL single_result: got idx=%0d cnt=%0d expected idx=0 cnt=10", res_idx, res_cnt);
    end
    n_checks++;
    if (ring_en !== '0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL single_report_en: got en=%b busy=%b expected 0/1", ring_en, busy);
    end
    dc0 = done_cnt;
    handshake(d);
    n_checks++;
    if (d !== 1'b1) begin n_fail++; $display("FAIL single_done: got %b expected 1", d); end
    @(negedge clk); ready = 1'b0; #1;
    n_checks++;
    if (busy !== 1'b0 || res_valid !== 1'b0) begin
      n_fail++; $display("FAIL single_idle: got busy=%b valid=%b expected 0/0", busy, res_valid);
    end
    n_checks++;
    if (done_cnt - dc0 != 1) begin n_fail++; $display("FAIL single_done_count: got %0d expected 1", done_cnt - dc0); end
  endtask

  task automatic test_multi;
    int cyc; logic [6:0] en; logic d;
    logic [2:0] exp_idx [3] = '{3'd1, 3'd4, 3'd6};
    logic [6:0] exp_en  [3] = '{7'b0000010, 7'b0010000, 7'b1000000};
    per = 4;
    multi_en = 1'b0;
    pulse_start(1'b0, 7'b1010010, 16'd8);
    for (int k = 0; k < 3; k++) begin
      wait_valid(1'b0, cyc, en);
      n_checks++;
      if (en !== exp_en[k]) begin n_fail++; $display("FAIL multi_en_%0d: got %b expected %b", k, en, exp_en[k]); end
      n_checks++;
      if (res_idx !== exp_idx[k] || res_cnt !== 16'd2) begin
        n_fail++; $display("FAIL multi_res_%0d: got idx=%0d cnt=%0d expected idx=%0d cnt=2", k, res_idx, res_cnt, exp_idx[k]);
      end
      handshake(d);
      n_checks++;
      if (d !== (k == 2)) begin n_fail++; $display("FAIL multi_done_%0d: got %b expected %b", k, d, k == 2); end
    end
    @(negedge clk); ready = 1'b0;
    n_checks++;
    if (multi_en) begin n_fail++; $display("FAIL multi_onehot: got more than one enable bit, expected at most one"); end
  endtask

  task automatic test_hold;
    int cyc; logic [6:0] en; logic d; int bad = 0;
    per = 5;
    pulse_start(1'b0, 7'b0000100, 16'd20);
    wait_valid(1'b0, cyc, en);
    n_checks++;
    if (res_idx !== 3'd2 || res_cnt !== 16'd4) begin
      n_fail++; $display("FAIL hold_result: got idx=%0d cnt=%0d expected idx=2 cnt=4", res_idx, res_cnt);
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      if (res_valid !== 1'b1 || res_idx !== 3'd2 || res_cnt !== 16'd4 || ring_en !== '0) bad++;
    end
    n_checks++;
    if (bad != 0) begin n_fail++; $display("FAIL hold_stable: got %0d unstable cycles expected 0", bad); end
    handshake(d);
    @(negedge clk); ready = 1'b0;
  endtask

  task automatic test_abort;
    int cyc; logic [6:0] en; logic d; int dc0; int vseen = 0;
    per = 10;
    dc0 = done_cnt;
    pulse_start(1'b0, 7'b0000011, 16'd100);
    for (int k = 1; k <= 56; k++) begin
      @(negedge clk);
      start = 1'b0; abort = 1'b0;
      if (k == 25) begin start = 1'b1; mask = 7'b1000000; end
      if (k == 26) begin
        #1;
        n_checks++;
        if (ring_en !== 7'b0000001 || busy !== 1'b1) begin
          n_fail++; $display("FAIL abort_start_ignored: got en=%b busy=%b expected 0000001/1", ring_en, busy);
        end
      end
      if (k == 55) abort = 1'b1;
    end
    #1;
    n_checks++;
    if (busy !== 1'b0 || ring_en !== '0 || res_valid !== 1'b0) begin
      n_fail++; $display("FAIL abort_idle: got busy=%b en=%b valid=%b expected 0", busy, ring_en, res_valid);
    end
    repeat (150) begin @(negedge clk); #1; if (res_valid || busy) vseen++; end
    n_checks++;
    if (vseen != 0 || done_cnt != dc0) begin
      n_fail++; $display("FAIL abort_quiet: got active=%0d done=%0d expected 0/0", vseen, done_cnt - dc0);
    end
    // abort wins over a simultaneous handshake
    pulse_start(1'b0, 7'b0000001, 16'd1);
    wait_valid(1'b0, cyc, en);
    @(negedge clk); ready = 1'b1; abort = 1'b1; #1;
    n_checks++;
    if (done_o !== 1'b0) begin n_fail++; $display("FAIL abort_hs_done: got %b expected 0", done_o); end
    @(negedge clk); ready = 1'b0; abort = 1'b0; #1;
    n_checks++;
    if (busy !== 1'b0 || res_valid !== 1'b0) begin
      n_fail++; $display("FAIL abort_hs_idle: got busy=%b valid=%b expected 0/0", busy, res_valid);
    end
  endtask

  task automatic test_window;
    int cyc; logic [6:0] en; logic d;
    per = 0;
    pulse_start(1'b0, 7'b0000001, 16'd0);
    wait_valid(1'b0, cyc, en);
    n_checks++;
    if (cyc != 6 || res_cnt !== 16'd0) begin
      n_fail++; $display("FAIL win0: got latency=%0d cnt=%0d expected 6/0", cyc, res_cnt);
    end
    handshake(d);
    per = 2;
    pulse_start(1'b0, 7'b0000001, 16'd2);
    wait_valid(1'b0, cyc, en);
    n_checks++;
    if (cyc != 7 || res_cnt !== 16'd1) begin
      n_fail++; $display("FAIL win2: got latency=%0d cnt=%0d expected 7/1", cyc, res_cnt);
    end
    handshake(d);
    per_s = 4;
    pulse_start(1'b1, 7'b0000001, 16'd100);
    wait_valid(1'b1, cyc, en);
    n_checks++;
    if (cyc != 105 || cnt_s !== 4'd15 || idx_s !== 3'd0) begin
      n_fail++; $display("FAIL saturate: got latency=%0d cnt=%0d idx=%0d expected 105/15/0", cyc, cnt_s, idx_s);
    end
    handshake(d);
    @(negedge clk); ready = 1'b0;
  endtask

  task automatic test_zero_and_reset;
    int cyc; logic [6:0] en;
    @(negedge clk); mask = '0; start = 1'b1;
    @(negedge clk); start = 1'b0; #1;
    n_checks++;
    if (done_o !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL zero_mask_done: got done=%b busy=%b expected 1/0", done_o, busy);
    end
    @(negedge clk); #1;
    n_checks++;
    if (done_o !== 1'b0 || busy !== 1'b0 || res_valid !== 1'b0) begin
      n_fail++; $display("FAIL zero_mask_after: got done=%b busy=%b valid=%b expected 0", done_o, busy, res_valid);
    end
    per = 2;
    pulse_start(1'b0, 7'b0000100, 16'd3);
    wait_valid(1'b0, cyc, en);
    @(negedge clk); rst = 1'b1; ready = 1'b1;
    @(negedge clk); #1;
    n_checks++;
    if ({ring_en, res_valid, res_idx, res_cnt, busy, done_o} !== '0) begin
      n_fail++; $display("FAIL reset_report: got en=%b v=%b idx=%0d cnt=%0d busy=%b done=%b expected 0",
                         ring_en, res_valid, res_idx, res_cnt, busy, done_o);
    end
    rst = 1'b0; ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    n_checks++;
    if (busy !== 1'b0 || res_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_quiet: got busy=%b valid=%b expected 0/0", busy, res_valid);
    end
  endtask

  task automatic test_continuous;
    int cyc; logic [6:0] en; logic d;
    per = 2; cont = 1'b1;
    pulse_start(1'b0, 7'b0000101, 16'd4);
    wait_valid(1'b0, cyc, en);
    handshake(d);
    wait_valid(1'b0, cyc, en);
    n_checks++;
    if (res_idx !== 3'd2 || res_cnt !== 16'd2) begin
      n_fail++; $display("FAIL cont_second: got idx=%0d cnt=%0d expected 2/2", res_idx, res_cnt);
    end
    handshake(d);
    n_checks++;
    if (d !== 1'b1) begin n_fail++; $display("FAIL cont_done: got %b expected 1", d); end
    wait_valid(1'b0, cyc, en);
    n_checks++;
    if (en !== 7'b0000001 || res_idx !== 3'd0) begin
      n_fail++; $display("FAIL cont_restart: got en=%b idx=%0d expected 0000001/0", en, res_idx);
    end
    @(negedge clk); abort = 1'b1; cont = 1'b0;
    @(negedge clk); abort = 1'b0; #1;
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL cont_abort: got busy=%b expected 0", busy); end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; start_s = 1'b0; abort = 1'b0; cont = 1'b0;
    ready = 1'b0; mask = '0; win = '0;
    test_reset();
    test_single();
    test_multi();
    test_hold();
    test_abort();
    test_window();
    test_zero_and_reset();
    test_continuous();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
